// File: rtl/subsample_2x2.sv
// 2x2 chroma downsampler: eight 8-pixel rows in, one 4x4 block of quad averages out.
// Optional round-half-up averaging is enabled by defining SUBSAMPLE_ROUND_EN.
`ifndef CH
`define CH 2
`endif

module subsample_2x2 #(
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [$clog2(`CH+1)-1:0]     ch_in,
  input  logic signed [DATA_W-1:0]     row_in [7:0],
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [$clog2(`CH+1)-1:0]     ch_out,
  output logic signed [DATA_W-1:0]     block_out [3:0][3:0]
);

  localparam int CW = $clog2(`CH+1);

  // Handshake: a row moves on valid_in && ready_in; a block moves on valid_out && ready_out.
  logic [2:0]               row_cnt;
  logic [CW-1:0]            ch_lat;
  logic signed [DATA_W:0]   psum [4];
  logic signed [DATA_W-1:0] work [3][4];
  logic signed [DATA_W:0]   pair [4];
  logic signed [DATA_W+1:0] sum  [4];
  logic signed [DATA_W-1:0] res  [4];
  logic                     xfer;
  logic                     load;
  logic                     chroma;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      pair[c] = $signed({row_in[2*c][DATA_W-1], row_in[2*c]})
              + $signed({row_in[2*c+1][DATA_W-1], row_in[2*c+1]});
      sum[c]  = $signed({psum[c][DATA_W], psum[c]})
              + $signed({pair[c][DATA_W], pair[c]});
`ifdef SUBSAMPLE_ROUND_EN
      res[c]  = DATA_W'((sum[c] + (DATA_W+2)'(2)) >>> 2);
`else
      res[c]  = DATA_W'(sum[c] >>> 2);
`endif
    end
  end

  // Only the last row of a block can stall, and only while the held block is unconsumed.
  assign ready_in = !(row_cnt == 3'd7 && valid_out && !ready_out);
  assign xfer     = valid_in && ready_in;
  assign chroma   = (ch_lat == CW'(1)) || (ch_lat == CW'(2));
  assign load     = xfer && (row_cnt == 3'd7) && chroma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt   <= '0;
      ch_lat    <= '0;
      ch_out    <= '0;
      valid_out <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        psum[c] <= '0;
        for (int r = 0; r < 3; r++) work[r][c] <= '0;
        for (int r = 0; r < 4; r++) block_out[r][c] <= '0;
      end
    end else begin
      if (xfer) begin
        row_cnt <= row_cnt + 3'd1;
        if (row_cnt == 3'd0) ch_lat <= ch_in;
        if (!row_cnt[0]) begin
          for (int c = 0; c < 4; c++) psum[c] <= pair[c];
        end else if (row_cnt[2:1] != 2'd3) begin
          for (int c = 0; c < 4; c++) work[row_cnt[2:1]][c] <= res[c];
        end
      end
      // The last output row goes straight from the adders to the output register.
      if (load) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 3; r++) block_out[r][c] <= work[r][c];
          block_out[3][c] <= res[c];
        end
        ch_out    <= ch_lat;
        valid_out <= 1'b1;
      end else if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_subsample_2x2.sv
// Self-checking bench for subsample_2x2: table-driven uniform blocks, scoreboard on every
// output handshake, and hand-written backpressure, reset-abort and gapped-input sequences.
`ifndef CH
`define CH 2
`endif

module tb_subsample_2x2;

`ifdef SUBSAMPLE_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_in;
  logic [1:0]        ch_in = 2'b00;
  logic signed [7:0] row_in [7:0];
  logic              valid_out;
  logic              ready_out = 1'b0;
  logic [1:0]        ch_out;
  logic signed [7:0] block_out [3:0][3:0];

  int n_pass = 0;
  int n_total = 0;
  int n_out = 0;
  int stalls = 0;
  logic [129:0]      exp_q[$];
  logic [1:0]        tb_ch = 2'b00;
  logic signed [7:0] blk [8][8];
  logic [129:0]      saved;

  typedef struct {
    logic [1:0] ch;
    int q0, q1, q2, q3;
    int exp;
  } rec_t;
  rec_t recs [4];

  subsample_2x2 #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .ch_in(ch_in), .row_in(row_in), .valid_out(valid_out), .ready_out(ready_out),
    .ch_out(ch_out), .block_out(block_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [129:0] got, input logic [129:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [129:0] pack_dut();
    logic [129:0] p;
    p[129:128] = ch_out;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) p[(i*4+j)*8 +: 8] = block_out[i][j];
    return p;
  endfunction

  // Reference average of each 2x2 quad, computed on plain integers.
  function automatic logic [129:0] model(input logic [1:0] ch);
    logic [129:0] p;
    int s;
    p[129:128] = ch;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = int'(blk[2*i][2*j]) + int'(blk[2*i][2*j+1])
          + int'(blk[2*i+1][2*j]) + int'(blk[2*i+1][2*j+1]) + 2*RND;
        s = s >>> 2;
        p[(i*4+j)*8 +: 8] = s[7:0];
      end
    return p;
  endfunction

  function automatic logic [129:0] all_same(input logic [1:0] ch, input int v);
    logic [129:0] p;
    p[129:128] = ch;
    for (int k = 0; k < 16; k++) p[k*8 +: 8] = v[7:0];
    return p;
  endfunction

  task automatic fill(input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'(v);
  endtask

  task automatic send_row(input int r, input logic [1:0] ch);
    int waited = 0;
    valid_in = 1'b1;
    ch_in = ch;
    for (int c = 0; c < 8; c++) row_in[c] = blk[r][c];
    @(negedge clk);
    while (!ready_in && waited < 200) begin
      stalls++;
      waited++;
      @(negedge clk);
    end
    if (!ready_in) begin
      n_total++;
      $display("FAIL row_timeout: row %0d not accepted, ready_in %b required 1", r, ready_in);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (r == 0) tb_ch = ch;
    if (r == 7 && (tb_ch == 2'b01 || tb_ch == 2'b10)) exp_q.push_back(model(tb_ch));
  endtask

  task automatic send_block(input logic [1:0] ch0, input logic [1:0] ch_rest, input bit gap);
    for (int r = 0; r < 8; r++) begin
      send_row(r, (r == 0) ? ch0 : ch_rest);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Scoreboard: every completed output handshake must match the oldest expected block.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got block %h, none expected", pack_dut());
      end else begin
        check("scoreboard", pack_dut(), exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [129:0] ramp;
    for (int c = 0; c < 8; c++) row_in[c] = '0;
    recs[0] = '{ch: 2'b01, q0: 10,   q1: 10,   q2: 10,   q3: 10,   exp: 10};
    recs[1] = '{ch: 2'b10, q0: 1,    q1: 2,    q2: 2,    q3: 2,    exp: 1 + RND};
    recs[2] = '{ch: 2'b10, q0: -128, q1: -128, q2: -128, q3: -128, exp: -128};
    recs[3] = '{ch: 2'b10, q0: -1,   q1: -2,   q2: -2,   q3: -2,   exp: -2};

    repeat (3) @(negedge clk);
    check("reset_outputs", pack_dut(), '0);
    check("reset_valid_out", {129'd0, valid_out}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {129'd0, ready_in}, 130'd1);
    @(posedge clk);
    #1;

    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          case ((r % 2) * 2 + (c % 2))
            0:       blk[r][c] = 8'(recs[k].q0);
            1:       blk[r][c] = 8'(recs[k].q1);
            2:       blk[r][c] = 8'(recs[k].q2);
            default: blk[r][c] = 8'(recs[k].q3);
          endcase
        end
      stalls = 0;
      send_block(recs[k].ch, recs[k].ch, 1'b0);
      @(negedge clk);
      check("rec_valid_out", {129'd0, valid_out}, 130'd1);
      check("rec_block", pack_dut(), all_same(recs[k].ch, recs[k].exp));
      if (k == 0) check("rec_no_stall", 130'(stalls), '0);
      @(posedge clk);
      #1;
    end

    // Luma/invalid tag on row 0 swallows the whole block.
    saved = pack_dut();
    fill(40);
    send_block(2'b00, 2'b01, 1'b0);
    repeat (2) @(negedge clk);
    check("y_valid_out", {129'd0, valid_out}, '0);
    check("y_block_unchanged", pack_dut(), saved);
    @(posedge clk);
    #1;

    // Back-to-back blocks under backpressure.
    ready_out = 1'b0;
    fill(20);
    send_block(2'b01, 2'b01, 1'b0);
    fill(-30);
    stalls = 0;
    for (int r = 0; r < 7; r++) send_row(r, 2'b01);
    check("b2b_rows_no_stall", 130'(stalls), '0);
    valid_in = 1'b1;
    for (int c = 0; c < 8; c++) row_in[c] = blk[7][c];
    @(negedge clk);
    check("b2b_row7_stalled", {129'd0, ready_in}, '0);
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    @(negedge clk);
    check("b2b_ready_released", {129'd0, ready_in}, 130'd1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    exp_q.push_back(model(2'b01));
    @(negedge clk);
    check("b2b_valid_held", {129'd0, valid_out}, 130'd1);
    check("b2b_second_block", pack_dut(), all_same(2'b01, -30));
    @(posedge clk);
    #1;

    // Abort a block with reset after row 4, then a clean Cr block.
    fill(7);
    for (int r = 0; r < 5; r++) send_row(r, 2'b01);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_reset_outputs", pack_dut(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill(5);
    send_block(2'b10, 2'b10, 1'b0);
    @(negedge clk);
    check("abort_new_block", pack_dut(), all_same(2'b10, 5));
    @(posedge clk);
    #1;

    // Ramp with valid_in toggling; each quad sum is 64i+8j+18, so rounding lifts the .5 case.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = 8'(8*r + c);
    send_block(2'b01, 2'b01, 1'b1);
    ramp[129:128] = 2'b01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ramp[(i*4+j)*8 +: 8] = 8'(16*i + 2*j + 4 + RND);
    check("ramp_block", pack_dut(), ramp);

    repeat (3) @(negedge clk);
    check("sb_drained", 130'(exp_q.size()), '0);
    check("output_count", 130'(n_out), 130'd8);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
